// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared state encoding, defaults and command builder
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_XFER,
    ST_CAPTURE,
    ST_GAP,
    ST_NEXT
  } state_e;

  localparam int          DEF_NUM_CH       = 4;
  localparam logic [15:0] DEF_CMD_TEMPLATE = 16'h8000;
  localparam int          DEF_CH_SHIFT     = 10;
  localparam int          DEF_GAP_CYC      = 4;
  localparam int          DEF_TIMEOUT_CYC  = 1023;

  // Channel bits shifted past bit 15 fall off the 16-bit word.
  function automatic logic [15:0] build_cmd(input logic [15:0] tmpl,
                                            input logic [3:0]  ch,
                                            input int          shift);
    logic [15:0] ch_w;
    ch_w = {12'h000, ch};
    return tmpl | (ch_w << shift);
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// rtl/seq_timeout_counter.sv - clearable up-counter flagging its last count
module seq_timeout_counter #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // tc marks the final enabled cycle, so an enabled run lasts exactly TIMEOUT_CYC clocks.
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/spi_adc_sequencer.sv
// rtl/spi_adc_sequencer.sv - per-trigger multi-channel SPI frame sequencer
module spi_adc_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          NUM_CH       = DEF_NUM_CH,
  parameter logic [15:0] CMD_TEMPLATE = DEF_CMD_TEMPLATE,
  parameter int          CH_SHIFT     = DEF_CH_SHIFT,
  parameter int          GAP_CYC      = DEF_GAP_CYC,
  parameter int          TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        clear_err,
  output logic        busy,
  output logic        start_transfer,
  output logic [15:0] data_to_tx,
  input  logic        cs,
  input  logic [15:0] data_rx,
  output logic        res_valid,
  output logic [3:0]  res_ch,
  output logic [15:0] res_data,
  output logic        frame_done,
  output logic        timeout_err,
  output logic        overrun_err
);

  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  state_e      state_q;
  logic [3:0]  ch_q;
  logic        busy_q, start_q, res_valid_q, frame_done_q, tmo_err_q, ovr_err_q;
  logic [15:0] tx_q, res_data_q;
  logic [3:0]  res_ch_q;

  logic in_wait, tmo_clr, tmo_tc, gap_tc, tmo_set, ovr_set;

  // One counter guards both waits; it restarts when LAUNCH hands over to XFER.
  assign in_wait = (state_q == ST_LAUNCH) || (state_q == ST_XFER);
  assign tmo_clr = !in_wait || ((state_q == ST_LAUNCH) && !cs);
  assign tmo_set = tmo_tc && (((state_q == ST_LAUNCH) && cs) || ((state_q == ST_XFER) && !cs));
  assign ovr_set = trigger && (busy_q || frame_done_q);

  seq_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmo_clr),
    .en_i  (in_wait),
    .tc_o  (tmo_tc)
  );

  seq_timeout_counter #(.TIMEOUT_CYC(GAP_CYC)) u_gap (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != ST_GAP),
    .en_i  (state_q == ST_GAP),
    .tc_o  (gap_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      tx_q         <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_data_q   <= '0;
      frame_done_q <= 1'b0;
      tmo_err_q    <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      res_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      tmo_err_q    <= tmo_set || (tmo_err_q && !clear_err);
      ovr_err_q    <= ovr_set || (ovr_err_q && !clear_err);
      case (state_q)
        ST_IDLE: begin
          // A trigger landing on the frame_done pulse is an overrun, not a new frame.
          if (trigger && !frame_done_q) begin
            ch_q    <= '0;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            tx_q    <= build_cmd(CMD_TEMPLATE, 4'd0, CH_SHIFT);
            state_q <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!cs) begin
            start_q <= 1'b0;
            state_q <= ST_XFER;
          end else if (tmo_tc) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (cs) begin
            state_q <= ST_CAPTURE;
          end else if (tmo_tc) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          res_data_q  <= data_rx;
          res_ch_q    <= ch_q;
          res_valid_q <= 1'b1;
          state_q     <= (GAP_CYC == 0) ? ST_NEXT : ST_GAP;
        end
        ST_GAP: begin
          if (gap_tc) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (ch_q == LAST_CH) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            ch_q    <= ch_q + 4'd1;
            start_q <= 1'b1;
            tx_q    <= build_cmd(CMD_TEMPLATE, ch_q + 4'd1, CH_SHIFT);
            state_q <= ST_LAUNCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign start_transfer = start_q;
  assign data_to_tx     = tx_q;
  assign res_valid      = res_valid_q;
  assign res_ch         = res_ch_q;
  assign res_data       = res_data_q;
  assign frame_done     = frame_done_q;
  assign timeout_err    = tmo_err_q;
  assign overrun_err    = ovr_err_q;

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// tb/tb_spi_adc_sequencer.sv - directed bench with loopback and stuck-master stubs
`timescale 1ns/1ps
module tb_spi_adc_sequencer;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  trig  = 3'b000;
  logic [2:0]  clr   = 3'b000;
  logic [2:0]  busy, st, rv, fd, te, oe;
  logic [2:0]  cs;
  logic [15:0] tx [3];
  logic [15:0] rx [3];
  logic [3:0]  rch [3];
  logic [15:0] rdata [3];

  int          mode [3];
  int          cyc = 0;
  int          rvn [3];
  int          rvc [3];
  logic [19:0] res [3][64];
  logic [19:0] exp_d0 [4];
  int          vec  = 0;
  int          errs = 0;

  logic [2:0]  act;
  int          scnt [3];
  logic [15:0] sh [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_adc_sequencer u_d0 (
    .clk(clk), .reset(rst_n), .trigger(trig[0]), .clear_err(clr[0]), .busy(busy[0]),
    .start_transfer(st[0]), .data_to_tx(tx[0]), .cs(cs[0]), .data_rx(rx[0]),
    .res_valid(rv[0]), .res_ch(rch[0]), .res_data(rdata[0]), .frame_done(fd[0]),
    .timeout_err(te[0]), .overrun_err(oe[0]));

  spi_adc_sequencer #(.TIMEOUT_CYC(16)) u_d1 (
    .clk(clk), .reset(rst_n), .trigger(trig[1]), .clear_err(clr[1]), .busy(busy[1]),
    .start_transfer(st[1]), .data_to_tx(tx[1]), .cs(cs[1]), .data_rx(rx[1]),
    .res_valid(rv[1]), .res_ch(rch[1]), .res_data(rdata[1]), .frame_done(fd[1]),
    .timeout_err(te[1]), .overrun_err(oe[1]));

  spi_adc_sequencer #(.NUM_CH(1), .GAP_CYC(0), .CMD_TEMPLATE(16'hA5A5)) u_d2 (
    .clk(clk), .reset(rst_n), .trigger(trig[2]), .clear_err(clr[2]), .busy(busy[2]),
    .start_transfer(st[2]), .data_to_tx(tx[2]), .cs(cs[2]), .data_rx(rx[2]),
    .res_valid(rv[2]), .res_ch(rch[2]), .res_data(rdata[2]), .frame_done(fd[2]),
    .timeout_err(te[2]), .overrun_err(oe[2]));

  // Master stubs: mode 0 loops tx back as rx, 1 never lowers cs, 2 never raises it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs  <= 3'b111;
      act <= 3'b000;
      for (int g = 0; g < 3; g++) begin
        rx[g]   <= 16'h0;
        scnt[g] <= 0;
        sh[g]   <= 16'h0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (!act[g]) begin
          if (st[g] && mode[g] != 1) begin
            cs[g]   <= 1'b0;
            act[g]  <= 1'b1;
            scnt[g] <= 0;
            sh[g]   <= tx[g];
          end
        end else begin
          scnt[g] <= scnt[g] + 1;
          if (mode[g] == 0 && scnt[g] >= 7) begin
            cs[g]  <= 1'b1;
            rx[g]  <= sh[g];
            act[g] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rv[g] && rvn[g] < 64) begin
        res[g][rvn[g]] <= {rch[g], rdata[g]};
        rvn[g]         <= rvn[g] + 1;
        rvc[g]         <= cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic trig_pulse(input int i);
    @(negedge clk); trig[i] = 1'b1;
    @(negedge clk); trig[i] = 1'b0;
  endtask

  task automatic clr_pulse(input int i);
    @(negedge clk); clr[i] = 1'b1;
    @(negedge clk); clr[i] = 1'b0;
  endtask

  task automatic wait_fd(input int i, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fd[i] === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vec++;
      if ({busy[i], st[i], rv[i], fd[i], te[i], oe[i]} !== 6'b0) begin
        errs++;
        $display("FAIL reset_flags[%0d]: got %b expected 000000", i, {busy[i], st[i], rv[i], fd[i], te[i], oe[i]});
      end
      vec++;
      if (tx[i] !== 16'h0 || rch[i] !== 4'h0 || rdata[i] !== 16'h0) begin
        errs++;
        $display("FAIL reset_data[%0d]: got tx=%h ch=%h data=%h expected all 0", i, tx[i], rch[i], rdata[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback;
    int base, at;
    base = rvn[0];
    trig_pulse(0);
    vec++;
    if (busy[0] !== 1'b1 || st[0] !== 1'b1 || tx[0] !== 16'h8000) begin
      errs++;
      $display("FAIL launch_ch0: got busy=%b start=%b tx=%h expected 1 1 8000", busy[0], st[0], tx[0]);
    end
    wait_fd(0, 400, at);
    #1;
    vec++;
    if (at < 0) begin errs++; $display("FAIL loop_frame_done: got none expected pulse"); end
    vec++;
    if (rvn[0] - base !== 4) begin errs++; $display("FAIL loop_count: got %0d expected 4", rvn[0] - base); end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (res[0][base + k] !== exp_d0[k]) begin
        errs++;
        $display("FAIL loop_res[%0d]: got %h expected %h", k, res[0][base + k], exp_d0[k]);
      end
    end
    vec++;
    if (at - rvc[0] !== 5) begin errs++; $display("FAIL loop_fd_latency: got %0d expected 5", at - rvc[0]); end
    vec++;
    if (busy[0] !== 1'b0) begin errs++; $display("FAIL loop_busy_end: got %b expected 0", busy[0]); end
    @(negedge clk);
    vec++;
    if (fd[0] !== 1'b0) begin errs++; $display("FAIL loop_fd_width: got %b expected 0", fd[0]); end
  endtask

  task automatic test_frame_done_trigger;
    int at;
    trig_pulse(0);
    wait_fd(0, 400, at);
    trig[0] = 1'b1;
    @(negedge clk); trig[0] = 1'b0;
    vec++;
    if (at < 0 || oe[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errs++;
      $display("FAIL fd_trigger: got at=%0d ovr=%b busy=%b expected ovr=1 busy=0", at, oe[0], busy[0]);
    end
    @(negedge clk);
    vec++;
    if (st[0] !== 1'b0) begin errs++; $display("FAIL fd_trigger_ignored: got start=%b expected 0", st[0]); end
    clr_pulse(0);
    vec++;
    if (oe[0] !== 1'b0) begin errs++; $display("FAIL ovr_clear: got %b expected 0", oe[0]); end
  endtask

  task automatic test_overrun;
    int base, at;
    base = rvn[0];
    trig_pulse(0);
    repeat (4) @(negedge clk);
    trig[0] = 1'b1;
    @(negedge clk); trig[0] = 1'b0;
    vec++;
    if (oe[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errs++;
      $display("FAIL overrun_set: got ovr=%b busy=%b expected 1 1", oe[0], busy[0]);
    end
    wait_fd(0, 400, at);
    #1;
    vec++;
    if (at < 0 || rvn[0] - base !== 4) begin
      errs++;
      $display("FAIL overrun_count: got at=%0d n=%0d expected 4 results", at, rvn[0] - base);
    end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (res[0][base + k] !== exp_d0[k]) begin
        errs++;
        $display("FAIL overrun_res[%0d]: got %h expected %h", k, res[0][base + k], exp_d0[k]);
      end
    end
    clr_pulse(0);
  endtask

  task automatic test_timeout_launch;
    int base, n;
    mode[1] = 1;
    base = rvn[1];
    n = 0;
    trig_pulse(1);
    for (int k = 0; k < 100; k++) begin
      if (st[1] !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    vec++;
    if (n !== 16) begin errs++; $display("FAIL tmo_launch_len: got %0d expected 16", n); end
    vec++;
    if (te[1] !== 1'b1 || busy[1] !== 1'b0 || rvn[1] !== base) begin
      errs++;
      $display("FAIL tmo_launch_state: got err=%b busy=%b res=%0d expected 1 0 0", te[1], busy[1], rvn[1] - base);
    end
    clr_pulse(1);
    vec++;
    if (te[1] !== 1'b0) begin errs++; $display("FAIL tmo_clear: got %b expected 0", te[1]); end
  endtask

  task automatic test_clear_set_wins;
    clr[1] = 1'b1;
    trig_pulse(1);
    for (int k = 0; k < 100; k++) begin
      if (st[1] !== 1'b1) break;
      @(negedge clk);
    end
    vec++;
    if (te[1] !== 1'b1) begin errs++; $display("FAIL set_wins: got %b expected 1", te[1]); end
    @(negedge clk);
    vec++;
    if (te[1] !== 1'b0) begin errs++; $display("FAIL held_clear: got %b expected 0", te[1]); end
    clr[1] = 1'b0;
  endtask

  task automatic test_timeout_xfer;
    int base, n;
    mode[1] = 2;
    base = rvn[1];
    n = 0;
    trig_pulse(1);
    for (int k = 0; k < 100; k++) begin
      if (busy[1] !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    vec++;
    if (n !== 18) begin errs++; $display("FAIL tmo_xfer_len: got %0d expected 18", n); end
    vec++;
    if (te[1] !== 1'b1 || rvn[1] !== base) begin
      errs++;
      $display("FAIL tmo_xfer_state: got err=%b res=%0d expected 1 0", te[1], rvn[1] - base);
    end
    mode[1] = 0;
    repeat (12) @(negedge clk);
    clr_pulse(1);
  endtask

  task automatic test_reset_midframe;
    int base, at;
    bit found;
    base = rvn[0];
    found = 1'b0;
    trig_pulse(0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rvn[0] - base >= 2 && cs[0] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    vec++;
    if (!found) begin errs++; $display("FAIL ch2_xfer_reach: got none expected cs low on ch2"); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy[0], st[0], rv[0], fd[0], te[0], oe[0]} !== 6'b0) begin
      errs++;
      $display("FAIL async_reset_flags: got %b expected 000000", {busy[0], st[0], rv[0], fd[0], te[0], oe[0]});
    end
    vec++;
    if (tx[0] !== 16'h0 || rch[0] !== 4'h0 || rdata[0] !== 16'h0) begin
      errs++;
      $display("FAIL async_reset_data: got tx=%h ch=%h data=%h expected all 0", tx[0], rch[0], rdata[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    base = rvn[0];
    trig_pulse(0);
    wait_fd(0, 400, at);
    #1;
    vec++;
    if (at < 0 || rvn[0] - base !== 4) begin
      errs++;
      $display("FAIL fresh_frame_count: got at=%0d n=%0d expected 4 results", at, rvn[0] - base);
    end
    vec++;
    if (res[0][base] !== exp_d0[0] || res[0][base + 3] !== exp_d0[3]) begin
      errs++;
      $display("FAIL fresh_frame_res: got %h %h expected %h %h", res[0][base], res[0][base + 3], exp_d0[0], exp_d0[3]);
    end
  endtask

  task automatic test_back_to_back;
    int base, at;
    base = rvn[2];
    trig_pulse(2);
    vec++;
    if (st[2] !== 1'b1 || tx[2] !== 16'hA5A5) begin
      errs++;
      $display("FAIL one_launch: got start=%b tx=%h expected 1 a5a5", st[2], tx[2]);
    end
    wait_fd(2, 200, at);
    #1;
    vec++;
    if (at < 0 || rvn[2] - base !== 1) begin
      errs++;
      $display("FAIL one_count: got at=%0d n=%0d expected 1 result", at, rvn[2] - base);
    end
    vec++;
    if (res[2][base] !== 20'h0A5A5) begin errs++; $display("FAIL one_res: got %h expected 0a5a5", res[2][base]); end
    vec++;
    if (at - rvc[2] !== 1) begin errs++; $display("FAIL one_fd_latency: got %0d expected 1", at - rvc[2]); end
    vec++;
    if (busy[2] !== 1'b0) begin errs++; $display("FAIL one_busy_end: got %b expected 0", busy[2]); end
    @(negedge clk); trig[2] = 1'b1;
    @(negedge clk); trig[2] = 1'b0;
    vec++;
    if (busy[2] !== 1'b1 || st[2] !== 1'b1 || oe[2] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_accept: got busy=%b start=%b ovr=%b expected 1 1 0", busy[2], st[2], oe[2]);
    end
    wait_fd(2, 200, at);
    #1;
    vec++;
    if (at < 0 || rvn[2] - base !== 2) begin
      errs++;
      $display("FAIL b2b_count: got at=%0d n=%0d expected 2 results", at, rvn[2] - base);
    end
  endtask

  initial begin
    exp_d0[0] = 20'h08000;
    exp_d0[1] = 20'h18400;
    exp_d0[2] = 20'h28800;
    exp_d0[3] = 20'h38C00;
    test_reset();
    test_loopback();
    test_frame_done_trigger();
    test_overrun();
    test_timeout_launch();
    test_clear_set_wins();
    test_timeout_xfer();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
